queue_arbiter: RTL
==================

# queue_arbiter

Two-requester arbiter and sequencer for the single-port 8-bit byte queue (128 entries; 8-bit front/back pointers, bit 7 is the wrap bit). Each requester posts a push or a pop through a request/grant handshake. The arbiter picks one requester round-robin and drives the queue's `En_i`/`RW_i`/`data_i` for exactly one cycle. It then returns the popped byte, or a reject for a push to a full queue or a pop from an empty one. It sits between the queue instance and two client blocks, so no client touches the queue pins directly.

## Interface
Parameters:
- `DATA_W`, 8, byte width; must match the queue data width.

Ports:
- `Clk_i`  in  1  system clock; all state changes on the rising edge.
- `Rst_i`  in  1  reset; one clock, synchronous, active-high.
- `ReqA_i` / `ReqB_i`  in  1  request from requester A / B; held until grant.
- `RWA_i` / `RWB_i`  in  1  operation: 1 = push (write), 0 = pop (read); stable while request high.
- `DataA_i` / `DataB_i`  in  DATA_W  push data; stable while request high.
- `GntA_o` / `GntB_o`  out  1  one-cycle grant pulse that completes the request.
- `ErrA_o` / `ErrB_o`  out  1  with grant: operation rejected (full on push, empty on pop).
- `RdataA_o` / `RdataB_o`  out  DATA_W  popped byte; valid only with grant, pop, and no error.
- `Q_En_o`  out  1  to queue `En_i`.
- `Q_RW_o`  out  1  to queue `RW_i`.
- `Q_data_o`  out  DATA_W  to queue `data_i`.
- `Q_data_i`  in  DATA_W  from queue `data_o`; combinational read of the front entry while `Q_En_o`=1 and `Q_RW_o`=0.
- `Q_empty_i` / `Q_full_i`  in  1  from queue `empty_o` / `full_o`.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If no request is high, stay.
  - Otherwise select a winner. If only one requester is high, it wins. If both are high, the requester named by `prio` wins.
  - Latch winner id, RW, and data into `own`, `op_rw`, `op_data`. Go to ISSUE.
- ISSUE:
  - Legal operation = (`op_rw`=1 and `Q_full_i`=0) or (`op_rw`=0 and `Q_empty_i`=0).
  - If legal: `Q_En_o`=1, `Q_RW_o`=`op_rw`, `Q_data_o`=`op_data`. On a pop, register `Q_data_i` into `rd_reg`.
  - If illegal: `Q_En_o`=0. Set `err_reg`=1.
  - Go to DONE.
- DONE:
  - Pulse `Gnt<own>_o`=1. Drive `Err<own>_o`=`err_reg` and `Rdata<own>_o`=`rd_reg`.
  - Set `prio` to the non-owner. Clear `err_reg`. Go to IDLE.
- Round-robin: `prio` flips only on a grant, including a rejected grant. A lone requester may win repeatedly.
- Handshake:
  - The requester keeps Req, RW, and Data stable from assertion until it sees its grant.
  - Req sampled high in the IDLE cycle after DONE counts as a new request. A requester with no further work drops Req in the cycle after its grant.
  - A request that loses stays pending. The loser wins the next IDLE because `prio` now points at it.
- Outputs to the non-owner requester are 0 in every state.
- `Q_data_o` is 0 and `Q_RW_o` is 0 whenever `Q_En_o`=0.
- Full/empty are sampled in ISSUE, never in IDLE. The queue pointers move only on the ISSUE edge, so flags are settled by the next ISSUE.
- Queue wrap-around is handled entirely inside the queue. The arbiter relies only on the full/empty flags.

## Timing
- Reset values: state=IDLE, `prio`=A, `err_reg`=0, `rd_reg`=0. All outputs are 0.
- Reset mid-operation: on the reset edge the FSM returns to IDLE and any latched operation is dropped, with no grant issued.
  - If `Rst_i` is high during ISSUE, `Q_En_o` is still driven that cycle. The queue is reset from the same system reset, so that operation is discarded as well.
- Latency: request high in IDLE at cycle t → `Q_En_o` at t+1 → grant at t+2.
- Throughput: one operation per 3 cycles, shared between both requesters.
- Simultaneous requests:
  - The loser waits exactly 3 cycles longer than the winner.
  - Requester A issues first after reset.
  - A push by A and a pop by B on an empty queue: B's pop is issued after A's push, so it succeeds.
- `Rdata*_o` is registered. It is sampled from the queue in ISSUE, so the value reflects the front entry before the pointer advance.

## Test plan
- Reset, then A pushes 0x5A: `Q_En_o`=1 and `Q_RW_o`=1 with `Q_data_o`=0x5A at t+1; `GntA_o`=1 and `ErrA_o`=0 at t+2. Then B pops: `GntB_o`=1, `RdataB_o`=0x5A, `ErrB_o`=0, `Q_empty_i`=1 afterwards.
- Pop from an empty queue by A: `Q_En_o` stays 0 all 3 cycles; `GntA_o`=1 with `ErrA_o`=1.
- Both request at the same cycle (A pushes 0x11, B pushes 0x22) after reset: A is granted at t+2 and B at t+5. Two later pops return 0x11 then 0x22.
- 128 pushes by A (0x00..0x7F), then push 0x80: the 129th push gets `ErrA_o`=1 with `Q_full_i`=1 and no `Q_En_o`. Then 128 pops by B return 0x00..0x7F in order across pointer wrap, and a further pop is rejected.
- Both requesters held high continuously for 20 grants: grants strictly alternate A, B, A, ...
- Assert `Rst_i` for one cycle during DONE of a pending B pop: no `GntB_o` pulse; all outputs are 0 the next cycle; `prio`=A.

Source files
------------

// File: rtl/queue_arbiter_if.sv
// Requester and queue-side signal bundle for queue_arbiter.
// slave  : the arbiter's view (requests and queue flags in, grants and queue controls out).
// master : the environment's view (client blocks plus the queue instance).
interface queue_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              ReqA_i,   ReqB_i;
  logic              RWA_i,    RWB_i;
  logic [DATA_W-1:0] DataA_i,  DataB_i;
  logic              GntA_o,   GntB_o;
  logic              ErrA_o,   ErrB_o;
  logic [DATA_W-1:0] RdataA_o, RdataB_o;
  logic              Q_En_o;
  logic              Q_RW_o;
  logic [DATA_W-1:0] Q_data_o;
  logic [DATA_W-1:0] Q_data_i;
  logic              Q_empty_i, Q_full_i;

  modport slave (
    input  ReqA_i, ReqB_i, RWA_i, RWB_i, DataA_i, DataB_i,
    input  Q_data_i, Q_empty_i, Q_full_i,
    output GntA_o, GntB_o, ErrA_o, ErrB_o, RdataA_o, RdataB_o,
    output Q_En_o, Q_RW_o, Q_data_o
  );

  modport master (
    output ReqA_i, ReqB_i, RWA_i, RWB_i, DataA_i, DataB_i,
    output Q_data_i, Q_empty_i, Q_full_i,
    input  GntA_o, GntB_o, ErrA_o, ErrB_o, RdataA_o, RdataB_o,
    input  Q_En_o, Q_RW_o, Q_data_o
  );
endinterface

// File: rtl/queue_arbiter.sv
// Round-robin arbiter/sequencer placing two requesters onto one single-port
// byte queue. Each operation takes IDLE -> ISSUE -> DONE: the winner is
// latched in IDLE, the queue is accessed (or the access rejected) in ISSUE
// using the flags of that cycle, and the grant is pulsed in DONE.
module queue_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  queue_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state_q, state_d;
  logic                own_q,     own_d;      // 0 = A, 1 = B
  logic                prio_q,    prio_d;     // requester that wins a tie
  logic                op_rw_q,   op_rw_d;
  logic [DATA_W-1:0]   op_data_q, op_data_d;
  logic                err_q,     err_d;
  logic [DATA_W-1:0]   rd_q,      rd_d;

  logic legal;
  logic issue_en;
  logic grant;

  // Legality uses the flags as seen in ISSUE; pointers only move on that edge.
  assign legal    = op_rw_q ? ~bus.Q_full_i : ~bus.Q_empty_i;
  assign issue_en = (state_q == ISSUE) && legal;

  // Next-state and operation latching for the three-step sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    own_d     = own_q;
    prio_d    = prio_q;
    op_rw_d   = op_rw_q;
    op_data_d = op_data_q;
    err_d     = err_q;
    rd_d      = rd_q;
    case (state_q)
      IDLE: begin
        if (bus.ReqA_i || bus.ReqB_i) begin
          // B wins when alone, or when both request and B holds priority.
          own_d     = bus.ReqB_i && (!bus.ReqA_i || prio_q);
          op_rw_d   = own_d ? bus.RWB_i   : bus.RWA_i;
          op_data_d = own_d ? bus.DataB_i : bus.DataA_i;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        err_d   = ~legal;
        // Captured before the pointer advance; zero unless this is a good pop.
        rd_d    = (legal && !op_rw_q) ? bus.Q_data_i : '0;
        state_d = DONE;
      end
      DONE: begin
        prio_d  = ~own_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset drops any in-flight operation.
  always_ff @(posedge Clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Rst_i) begin
      state_q   <= IDLE;
      own_q     <= 1'b0;
      prio_q    <= 1'b0;
      op_rw_q   <= 1'b0;
      op_data_q <= '0;
      err_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      prio_q    <= prio_d;
      op_rw_q   <= op_rw_d;
      op_data_q <= op_data_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
    end
  end

  // Queue controls are quiet (all zero) whenever no access is issued.
  assign bus.Q_En_o   = issue_en;
  assign bus.Q_RW_o   = issue_en && op_rw_q;
  assign bus.Q_data_o = issue_en ? op_data_q : '0;

  // A reset arriving in DONE suppresses the grant of the dropped operation.
  assign grant        = (state_q == DONE) && !Rst_i;

  assign bus.GntA_o   = grant && !own_q;
  assign bus.GntB_o   = grant &&  own_q;
  assign bus.ErrA_o   = bus.GntA_o && err_q;
  assign bus.ErrB_o   = bus.GntB_o && err_q;
  assign bus.RdataA_o = bus.GntA_o ? rd_q : '0;
  assign bus.RdataB_o = bus.GntB_o ? rd_q : '0;

endmodule
